// File: rtl/host_bus_pkg.sv
// host_bus_pkg: command codes, status byte, FSM state encoding and command decode helpers for the debug-host bus master
package host_bus_pkg;
  localparam logic [7:0] CMD_READ    = 8'h01;
  localparam logic [7:0] CMD_WRITE   = 8'h02;
  localparam logic [7:0] CMD_BREAD   = 8'h03;
  localparam logic [7:0] CMD_BWRITE  = 8'h04;
  localparam logic [7:0] CMD_RST_ON  = 8'hFE;
  localparam logic [7:0] CMD_RST_OFF = 8'hFF;
  localparam logic [7:0] STAT_TMO    = 8'hEE;
  typedef enum logic [3:0] {IDLE, ADDR, LEN, WDATA, WREQ, RREQ, RWAIT, RSEND, ACK} state_t;
  function automatic logic is_bus_cmd(input logic [7:0] b);
    return (b == CMD_READ) || (b == CMD_WRITE) || (b == CMD_BREAD) || (b == CMD_BWRITE);
  endfunction
  function automatic logic is_rst_cmd(input logic [7:0] b);
    return (b == CMD_RST_ON) || (b == CMD_RST_OFF);
  endfunction
endpackage

// File: rtl/host_word_serdes.sv
// host_word_serdes: LSB-first byte-to-word assembler (in_fire/in_data -> word, in_last on final byte) and word-to-byte serialiser (load/load_word -> out_valid/out_data/out_ready, out_last on final handshake), width DW
module host_word_serdes #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_fire,
  input  logic [7:0]    in_data,
  output logic          in_last,
  output logic [DW-1:0] word,
  input  logic          load,
  input  logic [DW-1:0] load_word,
  output logic          out_valid,
  output logic [7:0]    out_data,
  input  logic          out_ready,
  output logic          out_last
);
  localparam int DB = DW / 8;
  localparam int CW = DB > 1 ? $clog2(DB) : 1;
  localparam logic [CW-1:0] CLAST = CW'(DB - 1);
  logic [CW-1:0] icnt, ocnt;
  logic [DW-1:0] sreg;
  logic out_fire;
  assign in_last  = in_fire & (icnt == CLAST);
  assign out_fire = out_valid & out_ready;
  assign out_last = out_fire & (ocnt == CLAST);
  assign out_data = sreg[7:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      icnt <= '0;
      word <= '0;
    end else if (in_fire) begin
      icnt <= in_last ? '0 : icnt + CW'(1);
      word <= (word >> 8) | (DW'(in_data) << (DW - 8));
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ocnt      <= '0;
      sreg      <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      ocnt      <= '0;
      sreg      <= load_word;
      out_valid <= 1'b1;
    end else if (out_fire) begin
      ocnt      <= out_last ? '0 : ocnt + CW'(1);
      sreg      <= sreg >> 8;
      out_valid <= ~out_last;
    end
endmodule

// File: rtl/host_burst_ctrl.sv
// host_burst_ctrl: byte-stream command engine issuing single/burst word reads and writes on the valid/ready/rrvalid bus (ports: rx_* command bytes in, tx_* response bytes out, rst_n_out downstream reset, address/wvalid/wdata/wready/rvalid/rready/rrvalid/rdata bus); define BUS_TIMEOUT_EN for a TMO_CYC-cycle bus watchdog
module host_burst_ctrl
  import host_bus_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int LENW    = 8,
  parameter int TMO_CYC = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  input  logic          tx_ready,
  output logic          rst_n_out,
  output logic [AW-1:0] address,
  output logic          wvalid,
  output logic [DW-1:0] wdata,
  input  logic          wready,
  output logic          rvalid,
  input  logic          rready,
  input  logic          rrvalid,
  input  logic [DW-1:0] rdata
);
  localparam int AB = AW / 8;
  localparam int LB = LENW / 8;
  localparam int FB = AB > LB ? AB : LB;
  localparam int BW = FB > 1 ? $clog2(FB) : 1;
  localparam logic [BW-1:0] ALAST = BW'(AB - 1);
  localparam logic [BW-1:0] LLAST = BW'(LB - 1);
  state_t state, nstate;
  logic [7:0] cmd, ser_data;
  logic [LENW-1:0] len;
  logic [BW-1:0] bcnt;
  logic acc, wr, burst, last_beat, wd_fire, in_last, ser_valid, ser_last, ser_load, beat_adv, tmo, drop;
  assign acc       = rx_valid & rx_ready;
  assign wr        = (cmd == CMD_WRITE) | (cmd == CMD_BWRITE);
  assign burst     = (cmd == CMD_BREAD) | (cmd == CMD_BWRITE);
  assign last_beat = len == '0;
  assign wd_fire   = acc & (state == WDATA);
  // rrvalid is taken in RWAIT, or already in RREQ when it coincides with the rready handshake
  assign ser_load  = rrvalid & ((state == RWAIT) | ((state == RREQ) & rready));
  // a beat finishes on the write handshake, a watchdog abort, a discarded word, or the last read byte
  assign beat_adv  = ((state == WREQ) & (wready | tmo)) | (wd_fire & in_last & drop) | ((state == RSEND) & ser_last);
  host_word_serdes #(.DW(DW)) u_serdes (
    .clk       (clk),
    .rst       (rst),
    .in_fire   (wd_fire),
    .in_data   (rx_data),
    .in_last   (in_last),
    .word      (wdata),
    .load      (ser_load),
    .load_word (rdata),
    .out_valid (ser_valid),
    .out_data  (ser_data),
    .out_ready (tx_ready),
    .out_last  (ser_last)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nstate;
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (acc) nstate = is_bus_cmd(rx_data) ? ADDR : is_rst_cmd(rx_data) ? ACK : IDLE;
      ADDR:    if (acc && bcnt == ALAST) nstate = burst ? LEN : wr ? WDATA : RREQ;
      LEN:     if (acc && bcnt == LLAST) nstate = wr ? WDATA : RREQ;
      WDATA:   if (wd_fire && in_last) nstate = !drop ? WREQ : last_beat ? ACK : WDATA;
      WREQ:    if (wready || tmo) nstate = last_beat ? ACK : WDATA;
      RREQ:    if (rready) nstate = rrvalid ? RSEND : RWAIT;
               else if (tmo) nstate = ACK;
      RWAIT:   if (rrvalid) nstate = RSEND;
               else if (tmo) nstate = ACK;
      RSEND:   if (ser_last) nstate = last_beat ? IDLE : RREQ;
      ACK:     if (tx_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end
  always_comb begin
    rx_ready = (state == IDLE) | (state == ADDR) | (state == LEN) | (state == WDATA);
    wvalid   = state == WREQ;
    rvalid   = state == RREQ;
    tx_valid = (state == ACK) | ser_valid;
    tx_data  = state == ACK ? (drop ? STAT_TMO : cmd) : ser_data;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cmd       <= '0;
      address   <= '0;
      len       <= '0;
      bcnt      <= '0;
      rst_n_out <= 1'b1;
    end else begin
      if (acc && state == IDLE) begin
        cmd <= rx_data;
        len <= '0;
      end
      if (acc && state == IDLE && is_rst_cmd(rx_data)) rst_n_out <= rx_data == CMD_RST_OFF;
      if (acc && (state == ADDR || state == LEN)) bcnt <= bcnt == (state == ADDR ? ALAST : LLAST) ? '0 : bcnt + BW'(1);
      if (acc && state == ADDR) address <= (address >> 8) | (AW'(rx_data) << (AW - 8));
      if (acc && state == LEN) len <= (len >> 8) | (LENW'(rx_data) << (LENW - 8));
      if (beat_adv && !last_beat) begin
        address <= address + AW'(1);
        len     <= len - LENW'(1);
      end
    end
`ifdef BUS_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  localparam logic [TW-1:0] TLAST = TW'(TMO_CYC - 1);
  logic [TW-1:0] tcnt;
  // tcnt restarts on every state change, so it measures time spent in the current bus-wait state
  assign tmo = ((state == WREQ) | (state == RREQ) | (state == RWAIT)) & (tcnt == TLAST);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tcnt <= '0;
      drop <= 1'b0;
    end else begin
      tcnt <= nstate != state ? '0 : tcnt + TW'(1);
      drop <= tmo | (drop & ~(acc & (state == IDLE)));
    end
`else
  assign tmo  = 1'b0;
  assign drop = 1'b0;
`endif
endmodule

// File: tb/tb_host_burst_ctrl.sv
// tb_host_burst_ctrl: directed self-checking bench for host_burst_ctrl
module tb_host_burst_ctrl;
  logic clk = 1'b0;
  logic rst, rx_valid, rx_ready, tx_valid, tx_ready, rst_n_out, wvalid, wready, rvalid, rready, rrvalid;
  logic [7:0] rx_data, tx_data;
  logic [15:0] address, wdata, rdata;
  always #5 clk = ~clk;
  host_burst_ctrl #(.AW(16), .DW(16), .LENW(8), .TMO_CYC(16)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .rst_n_out(rst_n_out),
    .address(address), .wvalid(wvalid), .wdata(wdata), .wready(wready),
    .rvalid(rvalid), .rready(rready), .rrvalid(rrvalid), .rdata(rdata)
  );
  int n_cmp = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  logic [31:0] wlog[$];
  logic [15:0] ralog[$];
  logic [7:0] txlog[$];
  int wv_cyc = 0, rv_cyc = 0, both = 0, unstable = 0;
  logic held = 1'b0;
  logic [7:0] held_d = 8'h0;
  always @(negedge clk) begin
    if (wvalid && wready) wlog.push_back({address, wdata});
    if (rvalid && rready) ralog.push_back(address);
    if (tx_valid && tx_ready) txlog.push_back(tx_data);
    if (wvalid) wv_cyc++;
    if (rvalid) rv_cyc++;
    if (wvalid && rvalid) both++;
    if (held && (!tx_valid || tx_data != held_d)) unstable++;
    held = tx_valid && !tx_ready && !rst;
    held_d = tx_data;
  end
  function automatic logic [7:0] txb(input int i);
    if (i < txlog.size()) return txlog[i];
    return 8'hxx;
  endfunction
  function automatic logic [31:0] wlb(input int i);
    if (i < wlog.size()) return wlog[i];
    return 32'hxxxxxxxx;
  endfunction
  function automatic logic [15:0] rab(input int i);
    if (i < ralog.size()) return ralog[i];
    return 16'hxxxx;
  endfunction
  int rd_lat = 0, rr_lat = 0;
  logic tx_toggle = 1'b0;
  logic [15:0] rd_q[$];
  initial begin
    int rwait, pend;
    rwait = 0;
    pend = 0;
    rready = 1'b0;
    rrvalid = 1'b0;
    rdata = 16'h0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rready = 1'b0;
      rrvalid = 1'b0;
      tx_ready = tx_toggle ? !tx_ready : 1'b1;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          rrvalid = 1'b1;
          if (rd_q.size() > 0) rdata = rd_q.pop_front();
        end
      end
      if (rvalid && !rst) begin
        if (rwait == rd_lat) begin
          rready = 1'b1;
          rwait = 0;
          pend = rr_lat;
          if (rr_lat == 0) begin
            rrvalid = 1'b1;
            if (rd_q.size() > 0) rdata = rd_q.pop_front();
          end
        end else rwait++;
      end else rwait = 0;
    end
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data = b;
    while (!rx_ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) chk("rx_accept", {31'b0, rx_ready}, 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask
  task automatic wait_tx(input int n);
    int c;
    c = 0;
    while (txlog.size() < n && c < 500) begin
      @(posedge clk);
      #1;
      c++;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int tb0, wb0, rb0, wv0, rv0, un0;
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h0;
    wready = 1'b0;
    #12;
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rst_n_out", rst_n_out, 1);
    chk("rst_address", address, 0);
    chk("rst_wdata", wdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    wready = 1'b1;
    tb0 = txlog.size(); wb0 = wlog.size(); wv0 = wv_cyc;
    send(8'h02); send(8'h34); send(8'h12); send(8'hCD); send(8'hAB);
    chk("write_lat", wvalid, 1);
    wait_tx(tb0 + 1);
    idle(2);
    chk("write_beats", wlog.size() - wb0, 1);
    chk("write_wv_cycles", wv_cyc - wv0, 1);
    chk("write_addr_data", wlb(wb0), 32'h1234ABCD);
    chk("write_ack", txb(tb0), 8'h02);
    wready = 1'b0;
    rd_lat = 3; rr_lat = 2;
    rd_q.push_back(16'hBEEF);
    tb0 = txlog.size(); rb0 = ralog.size(); rv0 = rv_cyc;
    send(8'h01); send(8'h10); send(8'h00);
    chk("read_lat", rvalid, 1);
    wait_tx(tb0 + 2);
    idle(3);
    chk("read_rv_cycles", rv_cyc - rv0, 4);
    chk("read_addr", rab(rb0), 16'h0010);
    chk("read_b0", txb(tb0), 8'hEF);
    chk("read_b1", txb(tb0 + 1), 8'hBE);
    chk("read_bytes", txlog.size() - tb0, 2);
    wready = 1'b1;
    tb0 = txlog.size(); wb0 = wlog.size();
    send(8'h04); send(8'hFF); send(8'hFF); send(8'h02);
    send(8'h11); send(8'h11); send(8'h22); send(8'h22); send(8'h33); send(8'h33);
    wait_tx(tb0 + 1);
    idle(3);
    chk("bwrite_beats", wlog.size() - wb0, 3);
    chk("bwrite_0", wlb(wb0), 32'hFFFF1111);
    chk("bwrite_1_wrap", wlb(wb0 + 1), 32'h00002222);
    chk("bwrite_2", wlb(wb0 + 2), 32'h00013333);
    chk("bwrite_ack", txb(tb0), 8'h04);
    chk("bwrite_ack_count", txlog.size() - tb0, 1);
    wready = 1'b0;
    rd_lat = 0; rr_lat = 0; tx_toggle = 1'b1;
    rd_q.push_back(16'hA1B2);
    rd_q.push_back(16'hC3D4);
    tb0 = txlog.size(); rb0 = ralog.size(); un0 = unstable;
    send(8'h03); send(8'h00); send(8'h01); send(8'h01);
    wait_tx(tb0 + 4);
    idle(4);
    tx_toggle = 1'b0;
    chk("bread_beats", ralog.size() - rb0, 2);
    chk("bread_addr0", rab(rb0), 16'h0100);
    chk("bread_addr1", rab(rb0 + 1), 16'h0101);
    chk("bread_b0", txb(tb0), 8'hB2);
    chk("bread_b1", txb(tb0 + 1), 8'hA1);
    chk("bread_b2", txb(tb0 + 2), 8'hD4);
    chk("bread_b3", txb(tb0 + 3), 8'hC3);
    chk("bread_bytes", txlog.size() - tb0, 4);
    chk("tx_stable", unstable - un0, 0);
    tb0 = txlog.size();
    send(8'hFE);
    chk("rstn_assert", rst_n_out, 0);
    wait_tx(tb0 + 1);
    idle(2);
    chk("rstn_held", rst_n_out, 0);
    chk("ack_fe", txb(tb0), 8'hFE);
    send(8'hFF);
    chk("rstn_release", rst_n_out, 1);
    wait_tx(tb0 + 2);
    chk("ack_ff", txb(tb0 + 1), 8'hFF);
    send(8'h55);
    idle(5);
    chk("unknown_no_resp", txlog.size() - tb0, 2);
    chk("unknown_idle", rx_ready, 1);
    rd_lat = 100;
    tb0 = txlog.size();
    send(8'h01); send(8'h00); send(8'h00);
    idle(3);
    chk("abort_rvalid_pre", rvalid, 1);
    rst = 1'b1;
    #1;
    chk("abort_rvalid", rvalid, 0);
    chk("abort_rx_ready", rx_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd_lat = 0; rr_lat = 0;
    idle(5);
    chk("abort_no_resp", txlog.size() - tb0, 0);
    rd_q.push_back(16'h5A69);
    rb0 = ralog.size();
    send(8'h01); send(8'h22); send(8'h00);
    wait_tx(tb0 + 2);
    chk("post_abort_addr", rab(rb0), 16'h0022);
    chk("post_abort_b0", txb(tb0), 8'h69);
    chk("post_abort_b1", txb(tb0 + 1), 8'h5A);
`ifdef BUS_TIMEOUT_EN
    wready = 1'b0;
    tb0 = txlog.size(); wb0 = wlog.size(); wv0 = wv_cyc;
    send(8'h02); send(8'h00); send(8'h20); send(8'h77); send(8'h66);
    wait_tx(tb0 + 1);
    idle(2);
    chk("tmo_wv_cycles", wv_cyc - wv0, 16);
    chk("tmo_no_write", wlog.size() - wb0, 0);
    chk("tmo_status", txb(tb0), 8'hEE);
    rd_q.push_back(16'h1357);
    send(8'h01); send(8'h30); send(8'h00);
    wait_tx(tb0 + 3);
    chk("tmo_next_b0", txb(tb0 + 1), 8'h57);
    chk("tmo_next_b1", txb(tb0 + 2), 8'h13);
`endif
    idle(2);
    chk("no_dual_valid", both, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/host_burst_ctrl.md
Name: host_burst_ctrl

Overview:
Single-clock host command engine and the next generation of the debug-host bus master.
- Accepts a byte-stream command protocol: CMD, address, optional burst length, write data.
- Issues single or burst word transactions on the system bus using the same valid/ready/rrvalid handshake as the existing host.
- Returns read data and write acknowledgements as a byte stream.
- Sits between a byte transport (UART, or a JTAG bridge already synchronised to clk) and the SDRAM controller bus.

Parameters:
AW, 16, bus address width in bits; multiple of 8; AB = AW/8 address bytes.
DW, 16, bus data width in bits; multiple of 8; DB = DW/8 bytes per word.
LENW, 8, burst length field width; multiple of 8; beats = len+1, so 1..2^LENW.
TMO_CYC, 1024, watchdog limit in cycles; used only with BUS_TIMEOUT_EN.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous active-high reset.
rx_valid  in  1  command byte valid.
rx_data  in  8  command byte.
rx_ready  out  1  command byte accepted when rx_valid & rx_ready.
tx_valid  out  1  response byte valid.
tx_data  out  8  response byte.
tx_ready  in  1  response sink ready.
rst_n_out  out  1  downstream reset, active-low.
address  out  AW  word address.
wvalid  out  1  write request.
wdata  out  DW  write data.
wready  in  1  write accepted.
rvalid  out  1  read request.
rready  in  1  read accepted.
rrvalid  in  1  read response valid.
rdata  in  DW  read data.

Behaviour:
- Reset (async assert, sync release): state IDLE; rx_ready=1, tx_valid=0, wvalid=0, rvalid=0, rst_n_out=1, address=0, wdata=0. Reset mid-burst aborts with no response.
- Commands:
  - 0x01 READ, 0x02 WRITE, 0x03 BREAD, 0x04 BWRITE, 0xFE reset assert, 0xFF reset de-assert.
  - Unknown byte: discarded, stay in IDLE, no response.
- Field order: address AB bytes LSB first; for 0x03/0x04 only, length LENW/8 bytes LSB first; single commands use len=0.
- Write data: DB bytes LSB first, per beat.
- States: IDLE, ADDR, LEN, WDATA, WREQ, RREQ, RWAIT, RSEND, ACK.
  - rx_ready=1 only in IDLE, ADDR, LEN, WDATA.
  - Byte counter counts field bytes; the state advances on the last byte.
- Write path:
  - WDATA assembles one word, then WREQ registers wvalid=1.
  - wvalid, address and wdata are held stable until wready.
  - wvalid drops the cycle after the wready handshake.
  - If beats remain: address+1, go to WDATA. Otherwise go to ACK.
- Read path:
  - RREQ holds rvalid until rready.
  - RWAIT waits for rrvalid, capturing rdata the same cycle.
  - rrvalid arriving in the same cycle as rready is accepted.
  - RSEND emits DB bytes LSB first, obeying tx_ready.
  - Then address+1 and the next beat, or IDLE after the last beat.
  - Only one read is outstanding at a time.
- ACK: after the last write beat, emit one byte equal to the CMD, held until tx_ready, then IDLE.
- Address increment wraps modulo 2^AW.
- Length counter is LENW bits and counts down to 0.
- Reset commands:
  - 0xFE drives rst_n_out=0 registered one cycle after the CMD byte is accepted; 0xFF releases it.
  - Both send an ACK byte.
  - The block itself is not reset by these commands.
- Latency: first wvalid rises 1 cycle after the last data byte is accepted; first rvalid rises 1 cycle after the last address/length byte.
- Never both wvalid and rvalid high.
- tx_data is stable while tx_valid=1 and tx_ready=0.

Optional Feature:
BUS_TIMEOUT_EN.
- Defined: a counter clears on entering WREQ, RREQ or RWAIT and increments each cycle spent there.
  - On reaching TMO_CYC: drop wvalid/rvalid, abandon the remaining beats, emit status byte 0xEE, return to IDLE.
  - For BWRITE, the unsent write-data bytes of the remaining beats are still consumed from rx and discarded, to keep the stream framed.
- Undefined: no counter; the block waits indefinitely.

Decomposition:
- Package host_bus_pkg: command byte constants, state enum, status constants (0xEE).
- One sub-module, host_word_serdes: byte-to-word assembler and word-to-byte serialiser with per-byte valid/ready, parametrised by DW.

Test Plan:
- WRITE 02 34 12 CD AB, wready immediate -> one wvalid cycle with address=0x1234, wdata=0xABCD; tx byte 0x02.
- READ 01 10 00, rready delayed 3 cycles, rrvalid 2 cycles later with 0xBEEF -> rvalid held 4 cycles; tx bytes EF, BE.
- BWRITE 04 FF FF 02 + 3 words -> writes at addresses 0xFFFF, 0x0000, 0x0001 (wrap); single ACK 0x04.
- BREAD 03 00 01 01, tx_ready toggling every cycle -> 2 reads at 0x0100 and 0x0101; 4 bytes out in order, no duplicates or drops.
- FE then FF -> rst_n_out low from the cycle after FE until the cycle after FF; ACK bytes FE, FF; byte 0x55 -> no response and still in IDLE.
- BUS_TIMEOUT_EN, TMO_CYC=16, WRITE with wready never asserted -> wvalid drops after 16 cycles; tx 0xEE; next READ completes normally.
